// File: rtl/fp_simd_issue_q.sv
// Issue queue upstream of FP_SIMD: buffers vector ops, issues them one at a time, returns results over valid/ready.
// Optional macro FP_ISSUE_TIMEOUT_EN bounds the wait for fp_valid and flags aborted results on m_err.
module fp_simd_issue_q #(
  parameter int SIMD_WIDTH = 4,
  parameter int FP_W       = 22,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [2:0]                   s_opcode,
  input  logic [SIMD_WIDTH*FP_W-1:0]   s_in1,
  input  logic [SIMD_WIDTH*FP_W-1:0]   s_in2,
  output logic                         fp_en,
  output logic [2:0]                   fp_opcode,
  output logic [SIMD_WIDTH*FP_W-1:0]   fp_in1,
  output logic [SIMD_WIDTH*FP_W-1:0]   fp_in2,
  input  logic                         fp_valid,
  input  logic                         fp_busy,
  input  logic [SIMD_WIDTH*FP_W-1:0]   fp_result,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2:0]                   m_opcode,
  output logic [SIMD_WIDTH*FP_W-1:0]   m_result,
  output logic                         m_err,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int VW = SIMD_WIDTH * FP_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("fp_simd_issue_q: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  // IDLE: wait for head op and !fp_busy | ISSUE: first fp_en cycle | WAIT: for fp_valid | CAPTURE: latch+pop | OUT: hold for consumer
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CAPTURE, ST_OUT} state_e;
  state_e state_q, state_d;

  logic [2:0]    op_mem [DEPTH];
  logic [VW-1:0] a_mem  [DEPTH];
  logic [VW-1:0] b_mem  [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          fp_en_q, fp_en_d;
  logic [2:0]    fp_op_q, fp_op_d;
  logic [VW-1:0] fp_a_q, fp_a_d, fp_b_q, fp_b_d;
  logic          m_valid_q, m_valid_d;
  logic [2:0]    m_op_q, m_op_d;
  logic [VW-1:0] m_res_q, m_res_d;
  logic          push, pop, start, tmo_hit, abort;

  assign s_ready = (count_q < DEPTH_C);
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_CAPTURE);
  assign start   = (state_q == ST_IDLE) && (count_q != '0) && !fp_busy;

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q;
  logic          abort_q, m_err_q;

  assign tmo_hit = (state_q == ST_WAIT) && !fp_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= '0;
      abort_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      if (start) tmo_q <= '0;
      else if (state_q == ST_WAIT && !fp_valid) tmo_q <= tmo_q + 1'b1;
      if (state_q == ST_WAIT) abort_q <= tmo_hit;
      if (pop) m_err_q <= abort_q;
      else if (m_valid_q && m_ready) m_err_q <= 1'b0;
    end
  end

  assign abort = abort_q;
  assign m_err = m_err_q;
`else
  assign tmo_hit = 1'b0;
  assign abort   = 1'b0;
  assign m_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (fp_valid || tmo_hit) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_OUT;
      ST_OUT:     if (m_valid_q && m_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fp_en_d   = fp_en_q;
    fp_op_d   = fp_op_q;
    fp_a_d    = fp_a_q;
    fp_b_d    = fp_b_q;
    m_valid_d = m_valid_q;
    m_op_d    = m_op_q;
    m_res_d   = m_res_q;
    if (start) begin
      fp_en_d = 1'b1;
      fp_op_d = op_mem[rd_ptr_q];
      fp_a_d  = a_mem[rd_ptr_q];
      fp_b_d  = b_mem[rd_ptr_q];
    end
    if (pop) begin
      fp_en_d   = 1'b0;
      m_valid_d = 1'b1;
      m_op_d    = fp_op_q;
      m_res_d   = abort ? '0 : fp_result;
    end
    if (state_q == ST_OUT && m_valid_q && m_ready) m_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fp_en_q   <= 1'b0;
      fp_op_q   <= '0;
      fp_a_q    <= '0;
      fp_b_q    <= '0;
      m_valid_q <= 1'b0;
      m_op_q    <= '0;
      m_res_q   <= '0;
    end else begin
      state_q   <= state_d;
      fp_en_q   <= fp_en_d;
      fp_op_q   <= fp_op_d;
      fp_a_q    <= fp_a_d;
      fp_b_q    <= fp_b_d;
      m_valid_q <= m_valid_d;
      m_op_q    <= m_op_d;
      m_res_q   <= m_res_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q] <= s_opcode;
      a_mem[wr_ptr_q]  <= s_in1;
      b_mem[wr_ptr_q]  <= s_in2;
    end
  end

  assign fp_en     = fp_en_q;
  assign fp_opcode = fp_op_q;
  assign fp_in1    = fp_a_q;
  assign fp_in2    = fp_b_q;
  assign m_valid   = m_valid_q;
  assign m_opcode  = m_op_q;
  assign m_result  = m_res_q;
  assign count     = count_q;
endmodule

// File: tb/tb_fp_simd_issue_q.sv
// Scoreboard bench for fp_simd_issue_q with a behavioural FP_SIMD stand-in and randomized traffic.
module tb_fp_simd_issue_q;
  localparam int SW = 4, FW = 22, DEPTH = 4, TIMEOUT = 64, VW = SW * FW;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_RED = 3'd3;

  logic clk, rst, s_valid, s_ready, fp_en, fp_valid, fp_busy, m_valid, m_ready, m_err;
  logic [2:0] s_opcode, fp_opcode, m_opcode;
  logic [VW-1:0] s_in1, s_in2, fp_in1, fp_in2, fp_result, m_result;
  logic [$clog2(DEPTH):0] count;

  fp_simd_issue_q #(.SIMD_WIDTH(SW), .FP_W(FW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_opcode(s_opcode),
    .s_in1(s_in1), .s_in2(s_in2), .fp_en(fp_en), .fp_opcode(fp_opcode), .fp_in1(fp_in1),
    .fp_in2(fp_in2), .fp_valid(fp_valid), .fp_busy(fp_busy), .fp_result(fp_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_opcode(m_opcode), .m_result(m_result),
    .m_err(m_err), .count(count));

  typedef struct {logic [2:0] op; logic [VW-1:0] res; logic err;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  bit rand_ready = 0, rand_busy = 0, spurious_en = 0, fpm_stuck = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [FW-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[VW-1-i*FW -: FW];
  endfunction

  // Stand-in FP_SIMD arithmetic: lane-wise integer ops; the queue must pass everything bit-exact.
  function automatic logic [VW-1:0] fp_model(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    logic [FW-1:0] acc;
    logic [2*FW-1:0] p;
    r = '0;
    acc = '0;
    for (int i = 0; i < SW; i++) begin
      case (op)
        OP_ADD: r[VW-1-i*FW -: FW] = lane(a, i) + lane(b, i);
        OP_SUB: r[VW-1-i*FW -: FW] = lane(a, i) - lane(b, i);
        OP_MUL: begin
          p = {{FW{1'b0}}, lane(a, i)} * {{FW{1'b0}}, lane(b, i)};
          r[VW-1-i*FW -: FW] = p[FW-1:0];
        end
        OP_RED: acc = acc + lane(a, i);
        default: r[VW-1-i*FW -: FW] = lane(a, i) ^ lane(b, i);
      endcase
    end
    if (op == OP_RED) r[VW-1 -: FW] = acc;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) r[VW-1-i*FW -: FW] = FW'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle bound", name);
  endtask

  function automatic void expect_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b, input logic err);
    exp_t e;
    e.op = op;
    e.err = err;
    e.res = err ? '0 : fp_model(op, a, b);
    exp_q.push_back(e);
  endfunction

  // Called just after a rising edge; returns with the handshake complete.
  task automatic push_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic err, output int cnt_at_accept);
    int n;
    bit done;
    n = 0;
    done = 0;
    cnt_at_accept = -1;
    s_valid = 1; s_opcode = op; s_in1 = a; s_in2 = b;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        expect_op(op, a, b, err);
        cnt_at_accept = int'(count);
        done = 1;
      end else if (++n > 300) begin
        fail_bound("push_accept");
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_valid = 0;
  endtask

  task automatic drain(input string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      if (exp_q.size() == 0 && count == 0 && !m_valid && !fp_en) done = 1;
      n++;
    end
    if (!done) fail_bound(name);
    @(posedge clk); #1;
  endtask

  // FP_SIMD stand-in: responds 1..6 cycles after fp_en rises, holds fp_result until the next response.
  initial begin
    bit active, prev_en;
    int cnt;
    active = 0; prev_en = 0; cnt = 0;
    fp_valid = 0; fp_result = '0;
    forever begin
      @(posedge clk); #1;
      fp_valid = 0;
      if (!fp_en) active = 0;
      if (fp_en && !prev_en && !fpm_stuck) begin
        active = 1;
        cnt = $urandom_range(0, 5);
      end else if (active) begin
        if (cnt == 0) begin
          fp_valid = 1;
          fp_result = fp_model(fp_opcode, fp_in1, fp_in2);
          active = 0;
        end else cnt--;
      end else if (!fp_en && spurious_en && $urandom_range(0, 9) == 0) begin
        fp_valid = 1;
        fp_result = rand_vec();
      end
      prev_en = fp_en;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      if (rand_busy) fp_busy = ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: scoreboard pops on every output handshake, plus protocol invariants.
  initial begin
    logic hold, prev_en;
    logic [VW-1:0] h_res;
    logic [2:0] h_op;
    logic [2+2*VW:0] snap;
    int low_run;
    bit seen_en;
    exp_t e;
    hold = 0; prev_en = 0; low_run = 0; seen_en = 0; h_res = '0; h_op = '0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; prev_en = 0; low_run = 0; seen_en = 0;
        continue;
      end
      if (hold) begin
        check("hold_m_valid", m_valid, 1);
        check("hold_m_result", m_result, h_res);
        check("hold_m_opcode", m_opcode, h_op);
      end
      if (fp_en && prev_en) check("fp_operands_stable", {fp_opcode, fp_in1, fp_in2} == snap, 1);
      if (fp_en && !prev_en && seen_en) check("fp_en_low_gap", low_run >= 2, 1);
      if (fp_en) begin
        low_run = 0;
        seen_en = 1;
      end else low_run++;
      snap = {fp_opcode, fp_in1, fp_in2};
      prev_en = fp_en;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: opcode %0h result %0h with nothing outstanding", m_opcode, m_result);
        end else begin
          e = exp_q.pop_front();
          check("m_opcode", m_opcode, e.op);
          check("m_result", m_result, e.res);
          check("m_err", m_err, e.err);
        end
      end
      hold = m_valid && !m_ready;
      h_res = m_result;
      h_op = m_opcode;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    logic [VW-1:0] A, B;
    rst = 1; s_valid = 0; s_opcode = '0; s_in1 = '0; s_in2 = '0; fp_busy = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_fp_en", fp_en, 0);
    check("rst_fp_opcode", fp_opcode, 0);
    check("rst_fp_in1", fp_in1, 0);
    check("rst_fp_in2", fp_in2, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_result", m_result, 0);
    check("rst_m_opcode", m_opcode, 0);
    check("rst_m_err", m_err, 0);
    check("rst_count", count, 0);
    @(posedge clk); #1;
    rst = 0; m_ready = 1;

    // Single add: fp_en two cycles after push, m_valid two cycles after fp_valid.
    A = {22'h0F8000, 22'h100000, 22'h104000, 22'h108000};
    B = {22'h0F0000, 22'h100000, 22'h0F8000, 22'h0F8000};
    s_valid = 1; s_opcode = OP_ADD; s_in1 = A; s_in2 = B;
    @(negedge clk);
    check("t1_s_ready", s_ready, 1);
    expect_op(OP_ADD, A, B, 0);
    @(posedge clk); #1;
    s_valid = 0;
    @(negedge clk);
    check("t1_fp_en_T1", fp_en, 0);
    check("t1_count", count, 1);
    @(negedge clk);
    check("t1_fp_en_T2", fp_en, 1);
    check("t1_fp_opcode", fp_opcode, OP_ADD);
    check("t1_fp_in1", fp_in1, A);
    check("t1_fp_in2", fp_in2, B);
    n = 0;
    while (!fp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_bound("t1_fp_valid");
    @(negedge clk);
    check("t1_m_valid_capture", m_valid, 0);
    @(negedge clk);
    check("t1_m_valid_out", m_valid, 1);
    drain("t1_drain");

    // Back-to-back add, mul, sub.
    push_op(OP_ADD, A, B, 0, c);
    push_op(OP_MUL, A, B, 0, c);
    push_op(OP_SUB, A, B, 0, c);
    drain("t2_drain");

    // Fill with FP_SIMD busy; fifth op only after the first pop.
    fp_busy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      push_op(3'(i), rand_vec(), rand_vec(), 0, c);
      check("t3_count_at_push", c, i);
    end
    @(negedge clk);
    check("t3_full_count", count, DEPTH);
    check("t3_full_s_ready", s_ready, 0);
    @(posedge clk); #1;
    s_valid = 1; s_opcode = OP_SUB; s_in1 = A; s_in2 = B;
    repeat (3) begin
      @(negedge clk);
      check("t3_blocked_s_ready", s_ready, 0);
      check("t3_busy_no_issue", fp_en, 0);
      @(posedge clk); #1;
    end
    fp_busy = 0;
    push_op(OP_SUB, A, B, 0, c);
    check("t3_fifth_accept_count", c, DEPTH - 1);
    drain("t3_drain");

    // Consumer backpressure for 10 cycles.
    m_ready = 0;
    push_op(OP_MUL, rand_vec(), rand_vec(), 0, c);
    push_op(OP_ADD, rand_vec(), rand_vec(), 0, c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 100);
    if (!m_valid) fail_bound("t4_m_valid");
    repeat (10) begin
      @(negedge clk);
      check("t4_m_valid", m_valid, 1);
      check("t4_m_result", m_result, exp_q[0].res);
      check("t4_count", count, 1);
      check("t4_no_issue", fp_en, 0);
    end
    @(posedge clk); #1;
    m_ready = 1;
    drain("t4_drain");

    // Reduction: lane 0 carries the sum.
    push_op(OP_RED, A, B, 0, c);
    drain("t5_drain");

    // Reset while waiting on a silent FP_SIMD.
    fpm_stuck = 1;
    push_op(OP_SUB, A, B, 0, c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fp_en && n < 50);
    if (!fp_en) fail_bound("t6_fp_en");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    check("t6_fp_en", fp_en, 0);
    check("t6_count", count, 0);
    check("t6_m_valid", m_valid, 0);
    check("t6_s_ready", s_ready, 1);
    fpm_stuck = 0;
    @(posedge clk); #1;
    push_op(OP_ADD, B, A, 0, c);
    drain("t6_recover_drain");

`ifdef FP_ISSUE_TIMEOUT_EN
    fpm_stuck = 1;
    push_op(OP_MUL, A, B, 1, c);
    drain("tmo_drain");
    fpm_stuck = 0;
    push_op(OP_SUB, A, B, 0, c);
    drain("tmo_recover_drain");
`endif

    // Randomized traffic with random backpressure, busy and stray fp_valid pulses.
    rand_ready = 1; rand_busy = 1; spurious_en = 1;
    for (int i = 0; i < 40; i++) begin
      push_op(3'($urandom_range(0, 7)), rand_vec(), rand_vec(), 0, c);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 0; rand_busy = 0; spurious_en = 0;
    m_ready = 1; fp_busy = 0;
    drain("rand_drain");
    check("final_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
